// File: rtl/mouse_move_sequencer.sv
// Maps the mouse cursor to a 3x3 board cell and turns qualified left clicks
// into move requests for the game FSM over a req/ack/reject handshake.
// Ports: clk, reset (async, active-low); posX/posY cursor; buttons + mDoneTick
// mouse packet; turnEnable; moveAck/moveReject from game; moveReq/moveCell
// request; cursorCell hover cell (F = off board); timeoutTick; busy.
// Optional build macro: MOUSE_DEBOUNCE_EN (press needs DEBOUNCE_PKTS packets).
module mouse_move_sequencer #(
  parameter int BOARD_X0      = 170,
  parameter int BOARD_Y0      = 90,
  parameter int CELL_W        = 100,
  parameter int CELL_H        = 100,
  parameter int ACK_TIMEOUT   = 1000000,
  parameter int DEBOUNCE_PKTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] posX,
  input  logic [8:0] posY,
  input  logic [2:0] buttons,
  input  logic       mDoneTick,
  input  logic       turnEnable,
  input  logic       moveAck,
  input  logic       moveReject,
  output logic       moveReq,
  output logic [3:0] moveCell,
  output logic [3:0] cursorCell,
  output logic       timeoutTick,
  output logic       busy
);

  localparam int TW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REQ
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   cnt;
  logic [3:0]      press_cell;
  logic [3:0]      cell_n;
  logic [1:0]      col, row;
  logic            left, right, left_q;
  logic            press_evt, release_evt;
  logic            load, tick_n;
  logic            unused_ok;
  int              x, y;

  assign left      = buttons[0];
  assign right     = buttons[1];
  assign unused_ok = buttons[2] ^ (DEBOUNCE_PKTS > 1);

  always_comb begin
    x   = int'(posX);
    y   = int'(posY);
    col = 2'd3;
    row = 2'd3;
    if (x >= BOARD_X0 && x < BOARD_X0 + CELL_W)
      col = 2'd0;
    else if (x >= BOARD_X0 + CELL_W && x < BOARD_X0 + 2*CELL_W)
      col = 2'd1;
    else if (x >= BOARD_X0 + 2*CELL_W && x < BOARD_X0 + 3*CELL_W)
      col = 2'd2;
    if (y >= BOARD_Y0 && y < BOARD_Y0 + CELL_H)
      row = 2'd0;
    else if (y >= BOARD_Y0 + CELL_H && y < BOARD_Y0 + 2*CELL_H)
      row = 2'd1;
    else if (y >= BOARD_Y0 + 2*CELL_H && y < BOARD_Y0 + 3*CELL_H)
      row = 2'd2;
    if (col == 2'd3 || row == 2'd3)
      cell_n = 4'hF;
    else
      cell_n = 4'(row) * 4'd3 + 4'(col);
  end

  // left_q resets high so a button held through reset is not a press.
  assign release_evt = mDoneTick & ~left & left_q;

`ifdef MOUSE_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_PKTS + 1);
  logic [DW-1:0] db_cnt;
  logic          armed;

  assign press_evt = mDoneTick & left & armed &
                     (db_cnt == DW'(DEBOUNCE_PKTS - 1));

  // armed: left has been seen low since the last press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt <= '0;
      armed  <= 1'b0;
    end else if (mDoneTick) begin
      if (!left) begin
        db_cnt <= '0;
        armed  <= 1'b1;
      end else if (press_evt) begin
        db_cnt <= '0;
        armed  <= 1'b0;
      end else if (armed) begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end
`else
  assign press_evt = mDoneTick & left & ~left_q;
`endif

  always_comb begin
    state_n = state;
    load    = 1'b0;
    tick_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (press_evt && turnEnable && cursorCell != 4'hF) begin
          state_n = HOLD;
          load    = 1'b1;
        end
      end
      HOLD: begin
        if (!turnEnable)
          state_n = IDLE;
        else if (mDoneTick && right)
          state_n = IDLE;
        else if (release_evt)
          state_n = (cursorCell == press_cell) ? REQ : IDLE;
      end
      REQ: begin
        if (moveAck || moveReject) begin
          state_n = IDLE;
        end else if (cnt == TW'(ACK_TIMEOUT - 1)) begin
          state_n = IDLE;
          tick_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      press_cell  <= 4'd0;
      cursorCell  <= 4'hF;
      timeoutTick <= 1'b0;
      left_q      <= 1'b1;
    end else begin
      state       <= state_n;
      cursorCell  <= cell_n;
      timeoutTick <= tick_n;
      cnt         <= (state == REQ) ? cnt + 1'b1 : '0;
      if (load)
        press_cell <= cursorCell;
      if (mDoneTick)
        left_q <= left;
    end
  end

  assign moveReq  = (state == REQ);
  assign moveCell = press_cell;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mouse_move_sequencer.sv
// Self-checking bench for mouse_move_sequencer: directed steps plus
// randomized clicks checked against a division-based board/click model.
module tb_mouse_move_sequencer;

  localparam int X0  = 170;
  localparam int Y0  = 90;
  localparam int W   = 100;
  localparam int H   = 100;
  localparam int TO  = 16;
  localparam int DBP = 2;

  logic       clk;
  logic       reset;
  logic [9:0] posX;
  logic [8:0] posY;
  logic [2:0] buttons;
  logic       mDoneTick;
  logic       turnEnable;
  logic       moveAck;
  logic       moveReject;
  logic       moveReq;
  logic [3:0] moveCell;
  logic [3:0] cursorCell;
  logic       timeoutTick;
  logic       busy;

  int errors = 0;
  int checks = 0;

  mouse_move_sequencer #(
    .BOARD_X0(X0), .BOARD_Y0(Y0), .CELL_W(W), .CELL_H(H),
    .ACK_TIMEOUT(TO), .DEBOUNCE_PKTS(DBP)
  ) dut (
    .clk(clk), .reset(reset), .posX(posX), .posY(posY),
    .buttons(buttons), .mDoneTick(mDoneTick),
    .turnEnable(turnEnable), .moveAck(moveAck),
    .moveReject(moveReject), .moveReq(moveReq),
    .moveCell(moveCell), .cursorCell(cursorCell),
    .timeoutTick(timeoutTick), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int cell_of(input int px, input int py);
    if (px < X0 || px >= X0 + 3*W || py < Y0 || py >= Y0 + 3*H)
      return 15;
    return ((py - Y0) / H) * 3 + (px - X0) / W;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input int px, input int py);
    posX = 10'(px);
    posY = 9'(py);
    step();
    chk("cursor", {28'd0, cursorCell}, cell_of(px, py));
  endtask

  task automatic pkt(input logic l, input logic r);
    buttons   = {1'b0, r, l};
    mDoneTick = 1'b1;
    step();
    mDoneTick = 1'b0;
  endtask

  task automatic click(input int px, input int py, input int rx,
                       input int ry, input logic ten, output bit exp_req);
    bit hold_exp;
    turnEnable = ten;
    set_pos(px, py);
    pkt(1'b1, 1'b0);
    pkt(1'b1, 1'b0);
    hold_exp = ten && cell_of(px, py) != 15;
    chk("hold_busy", {31'd0, busy}, {31'd0, hold_exp});
    set_pos(rx, ry);
    pkt(1'b0, 1'b0);
    exp_req = hold_exp && cell_of(rx, ry) == cell_of(px, py);
    chk("req", {31'd0, moveReq}, {31'd0, exp_req});
    chk("busy", {31'd0, busy}, {31'd0, exp_req});
    chk("tick_idle", {31'd0, timeoutTick}, 0);
    if (exp_req)
      chk("cell", {28'd0, moveCell}, cell_of(px, py));
  endtask

  // kind: 0 ack, 1 reject, 2 ack+reject, 3 no answer (timeout)
  task automatic respond(input int kind, input int d);
    int hi;
    int ticks;
    hi    = 0;
    ticks = 0;
    if (kind == 3) begin
      for (int i = 0; i < TO - 1; i++) begin
        step();
        hi    += int'(moveReq);
        ticks += int'(timeoutTick);
      end
      chk("to_hold", hi, TO - 1);
      chk("to_early_tick", ticks, 0);
      step();
      chk("to_req", {31'd0, moveReq}, 0);
      chk("to_tick", {31'd0, timeoutTick}, 1);
      step();
      chk("to_tick_end", {31'd0, timeoutTick}, 0);
    end else begin
      for (int i = 0; i < d; i++) begin
        step();
        hi += int'(moveReq);
      end
      chk("ack_hold", hi, d);
      moveAck    = (kind != 1);
      moveReject = (kind != 0);
      step();
      moveAck    = 1'b0;
      moveReject = 1'b0;
      chk("ack_req", {31'd0, moveReq}, 0);
      chk("ack_busy", {31'd0, busy}, 0);
      chk("ack_tick", {31'd0, timeoutTick}, 0);
      step();
      chk("ack_tick2", {31'd0, timeoutTick}, 0);
    end
  endtask

  initial begin
    bit er;
    int px, py, rx, ry, kind;
    bit ten;
    reset      = 1'b0;
    posX       = 10'd0;
    posY       = 9'd0;
    buttons    = 3'b001;
    mDoneTick  = 1'b0;
    turnEnable = 1'b1;
    moveAck    = 1'b0;
    moveReject = 1'b0;
    #22;
    chk("rst_req", {31'd0, moveReq}, 0);
    chk("rst_cell", {28'd0, moveCell}, 0);
    chk("rst_cursor", {28'd0, cursorCell}, 15);
    chk("rst_tick", {31'd0, timeoutTick}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    reset = 1'b1;

    set_pos(320, 240);
    pkt(1'b1, 1'b0);
    pkt(1'b1, 1'b0);
    chk("held_at_reset", {31'd0, busy}, 0);
    pkt(1'b0, 1'b0);

    set_pos(220, 140);
    set_pos(500, 350);
    set_pos(169, 140);
    set_pos(270, 140);
    set_pos(269, 140);
    set_pos(469, 389);
    set_pos(470, 140);
    set_pos(220, 89);
    set_pos(220, 390);

    click(320, 240, 320, 240, 1'b1, er);
    respond(0, 0);

    click(220, 140, 320, 140, 1'b1, er);
    chk("diff_busy", {31'd0, busy}, 0);

    set_pos(220, 140);
    pkt(1'b1, 1'b0);
    pkt(1'b1, 1'b0);
    chk("rc_hold", {31'd0, busy}, 1);
    pkt(1'b1, 1'b1);
    chk("rc_cancel", {31'd0, busy}, 0);
    pkt(1'b0, 1'b0);
    chk("rc_req", {31'd0, moveReq}, 0);

    click(420, 140, 420, 140, 1'b1, er);
    respond(3, 0);
    click(420, 140, 420, 140, 1'b1, er);
    respond(1, 3);
    click(420, 140, 420, 140, 1'b1, er);
    respond(0, TO - 1);

    click(320, 240, 320, 240, 1'b0, er);
    set_pos(320, 240);
    turnEnable = 1'b1;
    pkt(1'b1, 1'b0);
    pkt(1'b1, 1'b0);
    chk("te_hold", {31'd0, busy}, 1);
    turnEnable = 1'b0;
    step();
    chk("te_drop", {31'd0, busy}, 0);
    turnEnable = 1'b1;
    pkt(1'b0, 1'b0);
    chk("te_req", {31'd0, moveReq}, 0);

    click(320, 340, 320, 340, 1'b1, er);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_req", {31'd0, moveReq}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    #20;
    reset = 1'b1;
    step();
    pkt(1'b0, 1'b0);

    set_pos(220, 340);
    pkt(1'b1, 1'b0);
`ifdef MOUSE_DEBOUNCE_EN
    chk("db_single", {31'd0, busy}, 0);
`else
    chk("db_single", {31'd0, busy}, 1);
`endif
    pkt(1'b1, 1'b0);
    chk("db_double", {31'd0, busy}, 1);
    pkt(1'b0, 1'b0);
    chk("db_req", {31'd0, moveReq}, 1);
    chk("db_cell", {28'd0, moveCell}, 6);
    respond(2, 1);

    for (int n = 0; n < 40; n++) begin
      px = $urandom_range(150, 490);
      py = $urandom_range(70, 410);
      if ($urandom_range(0, 2) != 0) begin
        rx = px;
        ry = py;
      end else begin
        rx = $urandom_range(150, 490);
        ry = $urandom_range(70, 410);
      end
      ten  = ($urandom_range(0, 5) != 0);
      kind = $urandom_range(0, 3);
      click(px, py, rx, ry, ten, er);
      if (er)
        respond(kind, $urandom_range(0, TO - 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
